// File: rtl/lut_cmp_seq_if.sv
// Valid/ready handshake bundle for lut_cmp_seq: operand in, 1-bit compare result out.
interface lut_cmp_seq_if #(
  parameter int WIDTH = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             Y;

  modport master (
    output IN_VALID, A, OUT_READY,
    input  IN_READY, OUT_VALID, Y
  );

  modport slave (
    input  IN_VALID, A, OUT_READY,
    output IN_READY, OUT_VALID, Y
  );
endinterface

// File: rtl/lut_cmp_seq.sv
// Chunk-serial compare of A against a constant, LUT_WIDTH bits per cycle, MSB chunk first.
// Define LUT_CMP_EARLY_EXIT_EN to finish on the first differing chunk (data-dependent latency).
module lut_cmp_seq #(
  parameter int               WIDTH     = 16,
  parameter int               LUT_WIDTH = 4,
  parameter int               OP        = 0,
  parameter int               SIGNED    = 0,
  parameter logic [WIDTH-1:0] CONST     = '0
) (
  input  logic         CLK,
  input  logic         SRST,
  lut_cmp_seq_if.slave bus
);

  localparam int NCHUNK = (WIDTH + LUT_WIDTH - 1) / LUT_WIDTH;
  localparam int PW     = NCHUNK * LUT_WIDTH;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("lut_cmp_seq: WIDTH must be >= 1");
  end
  if (LUT_WIDTH < 1 || LUT_WIDTH > 8) begin : g_bad_lut_width
    $error("lut_cmp_seq: LUT_WIDTH must be 1..8");
  end
  if (OP < 0 || OP > 3) begin : g_bad_op
    $error("lut_cmp_seq: OP must be 0..3");
  end

  // Flipping the sign bit turns a two's-complement compare into an unsigned one.
  function automatic logic [PW-1:0] prep(input logic [WIDTH-1:0] v);
    logic [PW-1:0] r;
    r            = '0;
    r[WIDTH-1:0] = v;
    if (SIGNED != 0) r[WIDTH-1] = ~r[WIDTH-1];
    return r;
  endfunction

  localparam logic [PW-1:0] CONST_P = prep(CONST);

  function automatic logic [LUT_WIDTH-1:0] const_chunk(input logic [CW-1:0] idx);
    logic [LUT_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == CW'(i)) r = CONST_P[(NCHUNK-1-i)*LUT_WIDTH +: LUT_WIDTH];
    end
    return r;
  endfunction

  function automatic logic map_op(input logic lt, input logic eq);
    case (OP)
      0:       return lt;
      1:       return lt | eq;
      2:       return !lt && !eq;
      default: return !lt;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            decided_q, decided_d;
  logic            lt_q, lt_d;
  logic            y_q, y_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  logic [LUT_WIDTH-1:0] a_chunk, c_chunk;
  logic                 differ, last, dec_n, lt_n, finish;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    cnt_d       = cnt_q;
    decided_d   = decided_q;
    lt_d        = lt_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    a_chunk = a_q[PW-1 -: LUT_WIDTH];
    c_chunk = const_chunk(cnt_q);
    differ  = (a_chunk != c_chunk);
    last    = (cnt_q == CW'(NCHUNK - 1));
    dec_n   = decided_q | differ;
    lt_n    = decided_q ? lt_q : (a_chunk < c_chunk);
`ifdef LUT_CMP_EARLY_EXIT_EN
    finish  = last || (!decided_q && differ);
`else
    finish  = last;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.IN_VALID) begin
          state_d    = S_SCAN;
          a_d        = prep(bus.A);
          cnt_d      = '0;
          decided_d  = 1'b0;
          lt_d       = 1'b0;
          in_ready_d = 1'b0;
        end
      end
      S_SCAN: begin
        a_d       = a_q << LUT_WIDTH;
        decided_d = dec_n;
        lt_d      = lt_n;
        if (finish) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          y_d         = map_op(lt_n, !dec_n);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (bus.OUT_READY) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      cnt_q       <= '0;
      decided_q   <= 1'b0;
      lt_q        <= 1'b0;
      y_q         <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      cnt_q       <= cnt_d;
      decided_q   <= decided_d;
      lt_q        <= lt_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Ready is masked by reset so no handshake can complete in a reset cycle.
  assign bus.IN_READY  = in_ready_q & ~SRST;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.Y         = y_q;

endmodule

// File: tb/tb_lut_cmp_seq.sv
// Directed bench for lut_cmp_seq: six parameterisations sharing one stimulus bus.
module tb_lut_cmp_seq;

  logic        clk       = 1'b0;
  logic        srst      = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a         = '0;
  int          cur       = 0;
  int          checks    = 0;
  int          errors    = 0;
  logic        rdy_s, vld_s, y_s;

  always #5 clk = ~clk;

  lut_cmp_seq_if #(.WIDTH(16)) if0 ();
  lut_cmp_seq_if #(.WIDTH(16)) if1 ();
  lut_cmp_seq_if #(.WIDTH(16)) if2 ();
  lut_cmp_seq_if #(.WIDTH(16)) if3 ();
  lut_cmp_seq_if #(.WIDTH(16)) if4 ();
  lut_cmp_seq_if #(.WIDTH(10)) if5 ();

  assign if0.IN_VALID = in_valid;  assign if0.A = a;       assign if0.OUT_READY = out_ready;
  assign if1.IN_VALID = in_valid;  assign if1.A = a;       assign if1.OUT_READY = out_ready;
  assign if2.IN_VALID = in_valid;  assign if2.A = a;       assign if2.OUT_READY = out_ready;
  assign if3.IN_VALID = in_valid;  assign if3.A = a;       assign if3.OUT_READY = out_ready;
  assign if4.IN_VALID = in_valid;  assign if4.A = a;       assign if4.OUT_READY = out_ready;
  assign if5.IN_VALID = in_valid;  assign if5.A = a[9:0];  assign if5.OUT_READY = out_ready;

  // unsigned lt 0x1234
  lut_cmp_seq #(.WIDTH(16), .LUT_WIDTH(4), .OP(0), .SIGNED(0), .CONST(16'h1234))
    u0 (.CLK(clk), .SRST(srst), .bus(if0));
  // unsigned ge 0x1234
  lut_cmp_seq #(.WIDTH(16), .LUT_WIDTH(4), .OP(3), .SIGNED(0), .CONST(16'h1234))
    u1 (.CLK(clk), .SRST(srst), .bus(if1));
  // unsigned gt 0x1234
  lut_cmp_seq #(.WIDTH(16), .LUT_WIDTH(4), .OP(2), .SIGNED(0), .CONST(16'h1234))
    u2 (.CLK(clk), .SRST(srst), .bus(if2));
  // signed gt -1
  lut_cmp_seq #(.WIDTH(16), .LUT_WIDTH(4), .OP(2), .SIGNED(1), .CONST(16'hFFFF))
    u3 (.CLK(clk), .SRST(srst), .bus(if3));
  // unsigned lt 0x0002
  lut_cmp_seq #(.WIDTH(16), .LUT_WIDTH(4), .OP(0), .SIGNED(0), .CONST(16'h0002))
    u4 (.CLK(clk), .SRST(srst), .bus(if4));
  // 10-bit signed le -512, padded top chunk
  lut_cmp_seq #(.WIDTH(10), .LUT_WIDTH(4), .OP(1), .SIGNED(1), .CONST(10'h200))
    u5 (.CLK(clk), .SRST(srst), .bus(if5));

  always_comb begin
    case (cur)
      0:       {rdy_s, vld_s, y_s} = {if0.IN_READY, if0.OUT_VALID, if0.Y};
      1:       {rdy_s, vld_s, y_s} = {if1.IN_READY, if1.OUT_VALID, if1.Y};
      2:       {rdy_s, vld_s, y_s} = {if2.IN_READY, if2.OUT_VALID, if2.Y};
      3:       {rdy_s, vld_s, y_s} = {if3.IN_READY, if3.OUT_VALID, if3.Y};
      4:       {rdy_s, vld_s, y_s} = {if4.IN_READY, if4.OUT_VALID, if4.Y};
      default: {rdy_s, vld_s, y_s} = {if5.IN_READY, if5.OUT_VALID, if5.Y};
    endcase
  end

  function automatic int exp_l(input int k, input int n);
`ifdef LUT_CMP_EARLY_EXIT_EN
    return k;
`else
    return n;
`endif
  endfunction

  // One transaction on DUT sel: accept, then count edges until OUT_VALID (lat_o = -1 on timeout).
  task automatic run_txn(input int sel, input logic [15:0] av,
                         output logic y_o, output int lat_o);
    int k;
    bit seen;
    cur       = sel;
    out_ready = 1'b1;
    lat_o     = -1;
    y_o       = 1'bx;
    seen      = 1'b0;
    #1;
    k = 0;
    while (!rdy_s && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b1;
    a        = av;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (vld_s) begin
          lat_o = j;
          y_o   = y_s;
          seen  = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    cur  = 0;
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy_s !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b want 0", rdy_s); end
    srst = 1'b0;
    #1;
    checks++;
    if (vld_s !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", vld_s); end
    checks++;
    if (y_s !== 1'b0) begin errors++; $display("FAIL reset_y got %b want 0", y_s); end
    checks++;
    if (rdy_s !== 1'b1) begin errors++; $display("FAIL reset_ready_high got %b want 1", rdy_s); end
    // A handshake attempted during reset must not be captured.
    srst     = 1'b1;
    in_valid = 1'b1;
    a        = 16'h0000;
    @(posedge clk); #1;
    srst     = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (rdy_s !== 1'b1) begin errors++; $display("FAIL reset_no_capture ready got %b want 1", rdy_s); end
  endtask

  task automatic test_unsigned_lt();
    logic [15:0] av [4] = '{16'h1233, 16'h0FFF, 16'h1235, 16'hFFFF};
    logic        ey [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int          ek [4] = '{4, 1, 4, 1};
    logic yv;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, av[i], yv, lat);
      checks++;
      if (yv !== ey[i]) begin errors++; $display("FAIL lt_y A=%h got %b want %b", av[i], yv, ey[i]); end
      checks++;
      if (lat !== exp_l(ek[i], 4)) begin
        errors++; $display("FAIL lt_latency A=%h got %0d want %0d", av[i], lat, exp_l(ek[i], 4));
      end
    end
  endtask

  task automatic test_ge_gt_equal();
    logic yv;
    int   lat;
    run_txn(1, 16'h1234, yv, lat);
    checks++;
    if (yv !== 1'b1) begin errors++; $display("FAIL ge_eq_y got %b want 1", yv); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL ge_eq_latency got %0d want 4", lat); end
    run_txn(1, 16'h1233, yv, lat);
    checks++;
    if (yv !== 1'b0) begin errors++; $display("FAIL ge_below_y got %b want 0", yv); end
    run_txn(2, 16'h1234, yv, lat);
    checks++;
    if (yv !== 1'b0) begin errors++; $display("FAIL gt_eq_y got %b want 0", yv); end
    run_txn(2, 16'h2000, yv, lat);
    checks++;
    if (yv !== 1'b1) begin errors++; $display("FAIL gt_above_y got %b want 1", yv); end
  endtask

  task automatic test_signed_gt();
    logic [15:0] av [3] = '{16'h0000, 16'h8000, 16'hFFFF};
    logic        ey [3] = '{1'b1, 1'b0, 1'b0};
    int          ek [3] = '{1, 1, 4};
    logic yv;
    int   lat;
    for (int i = 0; i < 3; i++) begin
      run_txn(3, av[i], yv, lat);
      checks++;
      if (yv !== ey[i]) begin errors++; $display("FAIL sgt_y A=%h got %b want %b", av[i], yv, ey[i]); end
      checks++;
      if (lat !== exp_l(ek[i], 4)) begin
        errors++; $display("FAIL sgt_latency A=%h got %0d want %0d", av[i], lat, exp_l(ek[i], 4));
      end
    end
  endtask

  task automatic test_backpressure();
    logic yv;
    int   lat;
    int   k;
    cur       = 0;
    out_ready = 1'b1;
    #1;
    k = 0;
    while (!rdy_s && k < 100) begin @(posedge clk); #1; k++; end
    in_valid  = 1'b1;
    a         = 16'h0FFF;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    k   = 0;
    while (!vld_s && k < 40) begin @(posedge clk); #1; k++; lat = k; end
    checks++;
    if (lat !== exp_l(1, 4)) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, exp_l(1, 4)); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (vld_s !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got %b want 1", i, vld_s); end
      checks++;
      if (y_s !== 1'b1) begin errors++; $display("FAIL bp_hold_y cyc=%0d got %b want 1", i, y_s); end
      checks++;
      if (rdy_s !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got %b want 0", i, rdy_s); end
      in_valid = 1'b1;
      a        = 16'hFFFF;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vld_s !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", vld_s); end
    checks++;
    if (rdy_s !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", rdy_s); end
    run_txn(0, 16'hFFFF, yv, lat);
    checks++;
    if (yv !== 1'b0) begin errors++; $display("FAIL bp_next_y got %b want 0", yv); end
    checks++;
    if (lat !== exp_l(1, 4)) begin errors++; $display("FAIL bp_next_latency got %0d want %0d", lat, exp_l(1, 4)); end
  endtask

  task automatic test_mid_scan_reset();
    logic yv;
    int   lat;
    int   k;
    run_txn(4, 16'h0001, yv, lat);
    checks++;
    if (yv !== 1'b1) begin errors++; $display("FAIL rst_pre_y got %b want 1", yv); end
    k = 0;
    @(posedge clk); #1;
    while (!rdy_s && k < 100) begin @(posedge clk); #1; k++; end
    in_valid = 1'b1;
    a        = 16'h0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (vld_s !== 1'b0) begin errors++; $display("FAIL rst_scan_valid got %b want 0", vld_s); end
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    #1;
    checks++;
    if (vld_s !== 1'b0) begin errors++; $display("FAIL rst_after_valid got %b want 0", vld_s); end
    checks++;
    if (y_s !== 1'b0) begin errors++; $display("FAIL rst_after_y got %b want 0", y_s); end
    checks++;
    if (rdy_s !== 1'b1) begin errors++; $display("FAIL rst_after_ready got %b want 1", rdy_s); end
    run_txn(4, 16'h0001, yv, lat);
    checks++;
    if (yv !== 1'b1) begin errors++; $display("FAIL rst_next_y got %b want 1", yv); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL rst_next_latency got %0d want 4", lat); end
  endtask

  task automatic test_sweep_10bit();
    logic        yv, ey;
    int          lat, ek;
    logic [11:0] pa;
    for (int v = 0; v < 1024; v++) begin
      run_txn(5, 16'(v), yv, lat);
      // Prepared constant is zero, so the first non-zero prepared chunk decides.
      pa = {2'b00, 10'(v) ^ 10'h200};
      ek = (pa[11:8] != 4'h0) ? 1 : (pa[7:4] != 4'h0) ? 2 : 3;
      ey = (v == 'h200);
      checks++;
      if (yv !== ey) begin errors++; $display("FAIL sweep_y A=%h got %b want %b", v[9:0], yv, ey); end
      checks++;
      if (lat !== exp_l(ek, 3)) begin
        errors++; $display("FAIL sweep_latency A=%h got %0d want %0d", v[9:0], lat, exp_l(ek, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_lt();
    test_ge_gt_equal();
    test_signed_gt();
    test_backpressure();
    test_mid_scan_reset();
    test_sweep_10bit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_cmp_seq.md
# lut_cmp_seq

Sequential comparator of a WIDTH-bit variable operand against a compile-time constant, evaluated LUT_WIDTH bits per cycle, MSB chunk first. Each chunk comparison is a single LUT_WIDTH-input function, so a wide comparison needs no carry chain. A valid/ready handshake on both sides lets the block sit as a multi-cycle stage in generated arithmetic datapaths. It produces the 1-bit result of `$lt`, `$le`, `$gt` or `$ge`, selected by parameter.

## Interface
- WIDTH, 16: operand width; must be ≥1.
- LUT_WIDTH, 4: bits compared per cycle; must be 1..8. NCHUNK = ceil(WIDTH/LUT_WIDTH).
- OP, 0: operation. 0=lt, 1=le, 2=gt, 3=ge. Any other value is an elaboration error.
- SIGNED, 0: 1 = two's-complement compare of A and CONST.
- CONST, 0: WIDTH-bit constant right-hand operand.
- CLK  input  1  clock; all state updates on the rising edge.
- SRST  input  1  reset; synchronous, active-high.
- IN_VALID  input  1  A is valid.
- IN_READY  output  1  block can accept A.
- A  input  WIDTH  variable left-hand operand.
- OUT_VALID  output  1  Y is valid.
- OUT_READY  input  1  consumer accepts Y.
- Y  output  1  result of (A OP CONST).

## Operation
- FSM states:
  - IDLE: IN_READY=1.
  - SCAN: processing chunks.
  - DONE: OUT_VALID=1.
- IDLE→SCAN on IN_VALID&IN_READY. On that edge:
  - A is captured into the operand shift register.
  - Chunk counter is cleared.
  - The decided flag and the lt flag are cleared.
- Operand preparation:
  - Both A and CONST are zero-extended to NCHUNK*LUT_WIDTH bits.
  - If SIGNED=1, bit WIDTH-1 of both is inverted before extension. An unsigned compare of the prepared values then equals the signed compare of the originals.
- Each SCAN cycle compares chunk i (from the MSB end) of the prepared A against chunk i of the prepared CONST:
  - If not yet decided and the chunks differ: decided←1, lt←(a_chunk < c_chunk).
  - Chunks after a decision cannot change the result.
  - The operand register shifts left by LUT_WIDTH each cycle.
- Result mapping, with eq = !decided:
  - lt → lt
  - le → lt|eq
  - gt → !lt&!eq
  - ge → !lt
- SCAN→DONE after the last chunk, or earlier under LUT_CMP_EARLY_EXIT_EN. Y is registered on this transition.
- DONE→IDLE on OUT_VALID&OUT_READY.
- Backpressure: Y and OUT_VALID hold stable while OUT_READY=0.
- IN_READY=0 in SCAN and DONE. IN_VALID in those states is ignored and no data is captured.
- Y keeps its last value outside DONE, but is only meaningful while OUT_VALID=1.
- Reset (any state, including mid-SCAN or in DONE):
  - Next cycle: state IDLE, OUT_VALID=0, Y=0, counters and flags cleared.
  - The in-flight transaction is dropped.
  - IN_READY=0 in any cycle where SRST=1. Handshakes in that cycle are ignored.

## Timing
- Accepting edge = edge 0.
- OUT_VALID rises after edge L:
  - L = NCHUNK when LUT_CMP_EARLY_EXIT_EN is not defined.
  - L = k when it is defined, where k is the 1-based index of the first differing chunk; L = NCHUNK if all chunks are equal.
- The output handshake at edge L+m returns the block to IDLE.
- IN_READY is high in the cycle after L+m, so the earliest next accept is edge L+m+1.
- Throughput: one result per L+2 cycles with OUT_READY held high.
- NCHUNK=1: L=1 in both configurations.

## Configuration
- LUT_CMP_EARLY_EXIT_EN defined:
  - SCAN→DONE on the cycle the first differing chunk is found.
  - Latency is data-dependent, 1..NCHUNK.
- Not defined:
  - Every transaction takes exactly NCHUNK SCAN cycles (constant latency).
  - Y is identical in both configurations.

## Test plan
1. Unsigned lt, WIDTH=16, LUT_WIDTH=4, CONST=16'h1234:
   - A=16'h1233 → Y=1, L=4 in both configurations.
   - A=16'h0FFF → Y=1, L=1 with EARLY_EXIT, L=4 without.
2. Unsigned ge, CONST=16'h1234, A=16'h1234 → Y=1, L=4 in both configurations. Same A with OP=gt → Y=0.
3. Signed gt, CONST=16'hFFFF (−1):
   - A=16'h0000 → Y=1.
   - A=16'h8000 → Y=0.
   - Both decided at chunk 1 (L=1 with EARLY_EXIT).
4. Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID rises.
   - Y and OUT_VALID stay stable; IN_READY=0.
   - IN_VALID pulses with A=16'hFFFF are not captured.
   - Releasing OUT_READY → IDLE next cycle; the next accept occurs one cycle later.
5. Assert SRST for 1 cycle at SCAN cycle 2.
   - Next cycle: OUT_VALID=0, Y=0, IN_READY=1.
   - The following transaction A=16'h0001 with unsigned lt, CONST=16'h0002 → Y=1.
6. WIDTH=10, LUT_WIDTH=4 (NCHUNK=3, padded top chunk), signed le, CONST=10'h200 (−512): sweep all 1024 values of A.
   - Y=1 only for A=10'h200.
   - Latency matches the rule in Timing for every value.
